// File: rtl/flash_arbiter.sv
// Two-requester round-robin front end for the flash_serial engine: grants one
// requester, sequences its burst of in_len+1 words, and returns/requests data.
module flash_arbiter #(
  parameter int WORD_BITS     = 8,
  parameter int ADDRESS_WORDS = 3,
  parameter int LEN_BITS      = 8
) (
  input  logic                                 in_clk,
  input  logic                                 in_rst,
  input  logic [1:0]                           in_req,
  input  logic [1:0]                           in_read,
  input  logic [2*WORD_BITS*ADDRESS_WORDS-1:0] in_addr,
  input  logic [2*LEN_BITS-1:0]                in_len,
  input  logic [2*WORD_BITS-1:0]               in_wdata,
  output logic [1:0]                           out_grant,
  output logic [WORD_BITS-1:0]                 out_rdata,
  output logic                                 out_rvalid,
  output logic                                 out_wnext,
  output logic                                 out_done,
  output logic                                 out_flash_enable,
  output logic                                 out_flash_read,
  output logic [WORD_BITS*ADDRESS_WORDS-1:0]   out_flash_addr,
  output logic [WORD_BITS-1:0]                 out_flash_data,
  input  logic [WORD_BITS-1:0]                 in_flash_data,
  input  logic                                 in_flash_next_word,
  input  logic                                 in_flash_word_finished
);

  localparam int AW = WORD_BITS * ADDRESS_WORDS;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_nw_q;
  logic                  r_wf_q;
  logic                  r_last_grant;
  logic                  r_sel;
  logic                  r_rw;
  logic [AW-1:0]         r_addr;
  logic [LEN_BITS-1:0]   r_len;
  logic [LEN_BITS-1:0]   r_word_ctr;
  logic [WORD_BITS-1:0]  r_rdata;
  logic                  r_rvalid;
  logic                  r_wnext;

  logic                  w_nw_rise;
  logic                  w_wf_fall;
  logic                  w_pick;
  logic                  w_last_word;

  assign w_nw_rise   = in_flash_next_word & ~r_nw_q;
  assign w_wf_fall   = ~in_flash_word_finished & r_wf_q;
  assign w_last_word = (r_word_ctr == r_len);
  // On a tie the requester not served last wins; otherwise whoever asks.
  assign w_pick      = (&in_req) ? ~r_last_grant : in_req[1];

  always_ff @(posedge in_clk) begin
    if (!in_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (|in_req) w_next = S_RUN;
      S_RUN:   if (w_nw_rise && w_last_word) w_next = S_DRAIN;
      S_DRAIN: if (w_wf_fall) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    out_flash_enable = 1'b0;
    out_flash_read   = 1'b1;
    out_grant        = 2'b00;
    out_done         = 1'b0;
    out_flash_data   = '0;
    unique case (r_state)
      S_IDLE: ;
      S_RUN: begin
        // Enable drops in the very cycle the engine asks for the word after the last.
        out_flash_enable = ~(w_nw_rise && w_last_word);
        out_flash_read   = r_rw;
        out_grant        = r_sel ? 2'b10 : 2'b01;
        out_flash_data   = r_rw ? '0 : (r_sel ? in_wdata[2*WORD_BITS-1:WORD_BITS]
                                              : in_wdata[WORD_BITS-1:0]);
      end
      S_DRAIN: begin
        out_flash_read = r_rw;
        out_grant      = r_sel ? 2'b10 : 2'b01;
        out_flash_data = r_rw ? '0 : (r_sel ? in_wdata[2*WORD_BITS-1:WORD_BITS]
                                            : in_wdata[WORD_BITS-1:0]);
      end
      S_DONE: begin
        out_flash_read = r_rw;
        out_done       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      r_nw_q       <= 1'b0;
      r_wf_q       <= 1'b0;
      r_last_grant <= 1'b1;
      r_sel        <= 1'b0;
      r_rw         <= 1'b1;
      r_addr       <= '0;
      r_len        <= '0;
      r_word_ctr   <= '0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
      r_wnext      <= 1'b0;
    end else begin
      r_nw_q   <= in_flash_next_word;
      r_wf_q   <= in_flash_word_finished;
      r_rvalid <= 1'b0;
      r_wnext  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (|in_req) begin
            r_sel      <= w_pick;
            r_rw       <= in_read[w_pick];
            r_addr     <= w_pick ? in_addr[2*AW-1:AW] : in_addr[AW-1:0];
            r_len      <= w_pick ? in_len[2*LEN_BITS-1:LEN_BITS] : in_len[LEN_BITS-1:0];
            r_word_ctr <= '0;
          end
        end
        S_RUN: begin
          if (w_wf_fall && (r_word_ctr < r_len)) begin
            r_word_ctr <= r_word_ctr + 1'b1;
            if (r_rw) begin
              r_rdata  <= in_flash_data;
              r_rvalid <= 1'b1;
            end else begin
              r_wnext  <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_wf_fall && r_rw) begin
            r_rdata  <= in_flash_data;
            r_rvalid <= 1'b1;
          end
        end
        S_DONE: r_last_grant <= r_sel;
        default: ;
      endcase
    end
  end

  assign out_flash_addr = r_addr;
  assign out_rdata      = r_rdata;
  assign out_rvalid     = r_rvalid;
  assign out_wnext      = r_wnext;

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter: a hand-sequenced engine model drives
// next_word / word_finished and each step checks against hand-derived values.
module tb_flash_arbiter;

  logic        in_clk = 1'b0;
  logic        in_rst;
  logic [1:0]  in_req;
  logic [1:0]  in_read;
  logic [47:0] in_addr;
  logic [15:0] in_len;
  logic [15:0] in_wdata;
  logic [1:0]  out_grant;
  logic [7:0]  out_rdata;
  logic        out_rvalid;
  logic        out_wnext;
  logic        out_done;
  logic        out_flash_enable;
  logic        out_flash_read;
  logic [23:0] out_flash_addr;
  logic [7:0]  out_flash_data;
  logic [7:0]  in_flash_data;
  logic        in_flash_next_word;
  logic        in_flash_word_finished;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_rvalid = 0, cnt_wnext = 0, cnt_done = 0, cnt_g11 = 0;
  int s_rvalid, s_wnext, s_done;

  flash_arbiter #(.WORD_BITS(8), .ADDRESS_WORDS(3), .LEN_BITS(8)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_req(in_req), .in_read(in_read),
    .in_addr(in_addr), .in_len(in_len), .in_wdata(in_wdata),
    .out_grant(out_grant), .out_rdata(out_rdata), .out_rvalid(out_rvalid),
    .out_wnext(out_wnext), .out_done(out_done),
    .out_flash_enable(out_flash_enable), .out_flash_read(out_flash_read),
    .out_flash_addr(out_flash_addr), .out_flash_data(out_flash_data),
    .in_flash_data(in_flash_data), .in_flash_next_word(in_flash_next_word),
    .in_flash_word_finished(in_flash_word_finished)
  );

  always #5 in_clk = ~in_clk;

  always @(negedge in_clk) begin
    if (out_rvalid) cnt_rvalid++;
    if (out_wnext)  cnt_wnext++;
    if (out_done)   cnt_done++;
    if (out_grant == 2'b11) cnt_g11++;
  end

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_rvalid = cnt_rvalid;
    s_wnext  = cnt_wnext;
    s_done   = cnt_done;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"},  {30'd0, out_grant}, 32'd0);
    chk({tag, "_rdata"},  {24'd0, out_rdata}, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, out_rvalid}, 32'd0);
    chk({tag, "_wnext"},  {31'd0, out_wnext}, 32'd0);
    chk({tag, "_done"},   {31'd0, out_done}, 32'd0);
    chk({tag, "_en"},     {31'd0, out_flash_enable}, 32'd0);
    chk({tag, "_fread"},  {31'd0, out_flash_read}, 32'd1);
    chk({tag, "_faddr"},  {8'd0, out_flash_addr}, 32'd0);
    chk({tag, "_fdata"},  {24'd0, out_flash_data}, 32'd0);
  endtask

  // One engine word: word_finished rises, next_word pulses mid-word, then
  // word_finished falls. d is the returned read word or the expected write word.
  task automatic run_word(input int r, input logic rd, input logic last,
                          input logic [7:0] d, input logic [7:0] nxt,
                          input logic [23:0] addr);
    logic [1:0] g;
    g = (r == 1) ? 2'b10 : 2'b01;
    in_flash_data = d;
    in_flash_word_finished = 1'b1;
    step();
    in_flash_next_word = 1'b1;
    #1;
    chk("en_at_nw", {31'd0, out_flash_enable}, {31'd0, ~last});
    chk("grant_run", {30'd0, out_grant}, {30'd0, g});
    chk("faddr", {8'd0, out_flash_addr}, {8'd0, addr});
    chk("fread", {31'd0, out_flash_read}, {31'd0, rd});
    chk("fdata", {24'd0, out_flash_data}, rd ? 32'd0 : {24'd0, d});
    step();
    in_flash_next_word = 1'b0;
    #1;
    chk("en_after_nw", {31'd0, out_flash_enable}, {31'd0, ~last});
    in_flash_word_finished = 1'b0;
    step();
    chk("rvalid", {31'd0, out_rvalid}, {31'd0, rd});
    if (rd) chk("rdata", {24'd0, out_rdata}, {24'd0, d});
    chk("wnext", {31'd0, out_wnext}, {31'd0, ~rd & ~last});
    chk("done", {31'd0, out_done}, {31'd0, last});
    if (!rd && !last) in_wdata[r*8 +: 8] = nxt;
    step();
    chk("rvalid_pulse", {31'd0, out_rvalid}, 32'd0);
    chk("wnext_pulse", {31'd0, out_wnext}, 32'd0);
    chk("done_pulse", {31'd0, out_done}, 32'd0);
  endtask

  initial begin
    in_rst = 1'b0;
    in_req = 2'b00;
    in_read = 2'b11;
    in_addr = '0;
    in_len = '0;
    in_wdata = '0;
    in_flash_data = '0;
    in_flash_next_word = 1'b0;
    in_flash_word_finished = 1'b0;
    step();
    step();
    chk_reset_outputs("rst");

    // Tie from reset; requester 0's first burst doubles as the single read.
    in_addr[23:0]  = 24'h000010;
    in_addr[47:24] = 24'h000020;
    in_req = 2'b11;
    snap();
    in_rst = 1'b1;
    #1;
    chk("grant_pre", {30'd0, out_grant}, 32'd0);
    step();
    chk("tie1_grant", {30'd0, out_grant}, 32'h1);
    chk("tie1_en", {31'd0, out_flash_enable}, 32'd1);
    run_word(0, 1'b1, 1'b1, 8'h5A, 8'h00, 24'h000010);
    chk("single_rdata_hold", {24'd0, out_rdata}, 32'h5A);
    chk("idle_grant", {30'd0, out_grant}, 32'd0);
    step();
    chk("tie2_grant", {30'd0, out_grant}, 32'h2);
    run_word(1, 1'b1, 1'b1, 8'h5B, 8'h00, 24'h000020);
    step();
    chk("tie3_grant", {30'd0, out_grant}, 32'h1);
    in_req = 2'b00;
    run_word(0, 1'b1, 1'b1, 8'h5C, 8'h00, 24'h000010);
    chk("tie_dones", cnt_done - s_done, 32'd3);
    chk("tie_rvalids", cnt_rvalid - s_rvalid, 32'd3);
    chk("grant_11", cnt_g11, 32'd0);

    // Burst read, requester 1, len 3.
    in_addr[47:24] = 24'h123456;
    in_len[15:8] = 8'd3;
    in_req = 2'b10;
    snap();
    step();
    chk("burst_grant", {30'd0, out_grant}, 32'h2);
    in_req = 2'b00;
    for (int i = 0; i < 4; i++)
      run_word(1, 1'b1, i == 3, 8'(i + 1), 8'h00, 24'h123456);
    chk("burst_rvalids", cnt_rvalid - s_rvalid, 32'd4);
    chk("burst_dones", cnt_done - s_done, 32'd1);

    // Write burst, requester 0, len 2.
    in_read = 2'b00;
    in_addr[23:0] = 24'hABCDEF;
    in_len[7:0] = 8'd2;
    in_wdata[7:0] = 8'h23;
    in_req = 2'b01;
    snap();
    step();
    chk("wr_grant", {30'd0, out_grant}, 32'h1);
    chk("wr_fread", {31'd0, out_flash_read}, 32'd0);
    in_req = 2'b00;
    run_word(0, 1'b0, 1'b0, 8'h23, 8'h24, 24'hABCDEF);
    run_word(0, 1'b0, 1'b0, 8'h24, 8'h25, 24'hABCDEF);
    run_word(0, 1'b0, 1'b1, 8'h25, 8'h00, 24'hABCDEF);
    chk("wr_wnexts", cnt_wnext - s_wnext, 32'd2);
    chk("wr_dones", cnt_done - s_done, 32'd1);

    // Coincident nw_rise and wf_fall at word_ctr == len-1 (len 2).
    in_read = 2'b11;
    in_addr[23:0] = 24'h000100;
    in_req = 2'b01;
    snap();
    step();
    in_req = 2'b00;
    run_word(0, 1'b1, 1'b0, 8'h11, 8'h00, 24'h000100);
    in_flash_data = 8'h22;
    in_flash_word_finished = 1'b1;
    step();
    in_flash_next_word = 1'b1;
    in_flash_word_finished = 1'b0;
    #1;
    chk("co_en_hold", {31'd0, out_flash_enable}, 32'd1);
    step();
    chk("co_rvalid", {31'd0, out_rvalid}, 32'd1);
    chk("co_rdata", {24'd0, out_rdata}, 32'h22);
    chk("co_en_run", {31'd0, out_flash_enable}, 32'd1);
    in_flash_next_word = 1'b0;
    in_flash_data = 8'h33;
    in_flash_word_finished = 1'b1;
    step();
    in_flash_next_word = 1'b1;
    #1;
    chk("co_en_drop", {31'd0, out_flash_enable}, 32'd0);
    step();
    in_flash_next_word = 1'b0;
    #1;
    chk("co_en_drain", {31'd0, out_flash_enable}, 32'd0);
    in_flash_word_finished = 1'b0;
    step();
    chk("co_last_rdata", {24'd0, out_rdata}, 32'h33);
    chk("co_done", {31'd0, out_done}, 32'd1);
    step();
    chk("co_rvalids", cnt_rvalid - s_rvalid, 32'd3);

    // Reset during the 2nd word of a len-5 read.
    in_len[7:0] = 8'd5;
    in_req = 2'b01;
    step();
    in_req = 2'b00;
    run_word(0, 1'b1, 1'b0, 8'h77, 8'h00, 24'h000100);
    in_flash_data = 8'h88;
    in_flash_word_finished = 1'b1;
    step();
    in_flash_next_word = 1'b1;
    step();
    in_flash_next_word = 1'b0;
    snap();
    in_rst = 1'b0;
    step();
    chk_reset_outputs("midrst");
    in_flash_word_finished = 1'b0;
    step();
    in_rst = 1'b1;
    step();
    chk("midrst_nodone", cnt_done - s_done, 32'd0);
    in_addr[47:24] = 24'h000777;
    in_len[15:8] = 8'd0;
    in_req = 2'b10;
    step();
    chk("fresh_grant", {30'd0, out_grant}, 32'h2);
    in_req = 2'b00;
    run_word(1, 1'b1, 1'b1, 8'h99, 8'h00, 24'h000777);

    // Maximum length burst: 256 words, counter must stop at len.
    in_len[15:8] = 8'hFF;
    in_req = 2'b10;
    snap();
    step();
    in_req = 2'b00;
    for (int i = 0; i < 256; i++)
      run_word(1, 1'b1, i == 255, 8'(i), 8'h00, 24'h000777);
    chk("max_rvalids", cnt_rvalid - s_rvalid, 32'd256);
    chk("max_dones", cnt_done - s_done, 32'd1);
    chk("grant_11_end", cnt_g11, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flash_arbiter.md
# flash_arbiter

- Arbitrates the single `flash_serial` engine between two requesters, e.g. a boot loader reading configuration and a logger writing data.
- Sequences bursts of up to 2^LEN_BITS consecutive words for the granted requester:
  - keeps the engine's command enable asserted across words;
  - ends each burst cleanly on the engine's "almost finished" indication.
- Returns read words with a valid strobe and requests fresh write words with a next-word strobe.
- Sits between the requesters and the `flash_serial` instance, which still drives the flash pins.

## Interface

- WORD_BITS, 8, bits per flash word
- ADDRESS_WORDS, 3, address width in words (address = WORD_BITS*ADDRESS_WORDS bits)
- LEN_BITS, 8, burst length field width; burst = in_len+1 words

- in_clk  in  1  system clock; one clock, all logic on rising edge
- in_rst  in  1  reset, synchronous, active-low
- in_req  in  2  request per requester; sampled only in Idle
- in_read  in  2  per requester: 1 = read burst, 0 = write burst
- in_addr  in  2*WORD_BITS*ADDRESS_WORDS  start address; requester i at [i*AW +: AW]
- in_len  in  2*LEN_BITS  burst length minus one, per requester
- in_wdata  in  2*WORD_BITS  write word, per requester
- out_grant  out  2  one-hot; high from grant until Done
- out_rdata  out  WORD_BITS  last read word, registered
- out_rvalid  out  1  one-cycle strobe, out_rdata valid
- out_wnext  out  1  one-cycle strobe: present the next write word
- out_done  out  1  one-cycle strobe at end of burst
- out_flash_enable  out  1  to engine in_enable
- out_flash_read  out  1  to engine in_read
- out_flash_addr  out  WORD_BITS*ADDRESS_WORDS  to engine in_addr
- out_flash_data  out  WORD_BITS  to engine in_data
- in_flash_data  in  WORD_BITS  from engine out_data
- in_flash_next_word  in  1  from engine out_next_word
- in_flash_word_finished  in  1  from engine out_word_finished

## Operation

- **Edge detection:** registered copies of in_flash_next_word and in_flash_word_finished.
  - nw_rise = rising edge of in_flash_next_word.
  - wf_fall = falling edge of in_flash_word_finished; this is the word-complete event.
- **States:** Idle, Run, Drain, Done.
- **Idle:**
  - If any in_req bit is high, grant by round-robin. With both requesting, grant the one not granted last.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - On grant, latch into sel, rw, addr, len and reset word_ctr to 0; next state Run.
- **Run:**
  - out_flash_enable = 1, except it is driven 0 combinationally in the cycle where nw_rise occurs and word_ctr == len. That cycle also transitions to Drain.
  - On wf_fall with word_ctr < len, increment word_ctr.
  - Read burst: on each such wf_fall, latch in_flash_data into out_rdata and pulse out_rvalid.
  - Write burst: on each such wf_fall, pulse out_wnext.
- **Drain:**
  - out_flash_enable = 0.
  - On wf_fall: for a read, latch the final word and pulse out_rvalid; then go to Done.
- **Done:** pulse out_done; clear out_grant; set last_grant = sel; go to Idle.
- **Engine outputs:**
  - out_flash_read = rw (1 in Idle).
  - out_flash_addr = latched start address; the engine auto-increments within a burst.
  - out_flash_data = in_wdata slice of sel (combinational pass-through); zero when not writing.
- **Requester obligations:**
  - A write requester presents word 0 before raising in_req.
  - After each out_wnext it updates in_wdata on the next cycle and holds it until the next out_wnext or out_done.
- **Boundary behaviour:**
  - Dropping in_req mid-burst is ignored; the burst completes.
  - A request arriving during Run, Drain or Done waits for Idle.
  - nw_rise and wf_fall in the same cycle: process both. The enable decision uses the pre-increment word_ctr.
  - len = 0: enable drops at the first nw_rise.
  - len at maximum (2^LEN_BITS − 1): word_ctr must not overflow; it is LEN_BITS wide and stops at len.
- **Reset:** in_rst low at a clock edge, including mid-burst, forces:
  - state Idle, last_grant = 1, word_ctr = 0;
  - out_grant = 0, out_rdata = 0, out_rvalid = 0, out_wnext = 0, out_done = 0;
  - out_flash_enable = 0, out_flash_read = 1, out_flash_addr = 0, out_flash_data = 0.

## Timing

- **Grant latency:** in_req sampled high in Idle at edge N → state Run, out_grant and out_flash_enable high from N+1.
- **Word timing:** out_rvalid / out_wnext occur one cycle after the engine's word_finished falling edge, since the edge is detected on registered copies.
- **End of burst:** out_done one cycle after the final wf_fall. Idle follows one cycle later, so the minimum gap between bursts is 2 cycles with enable low.
- **Enable hand-off:** enable deassertion occurs in the same cycle as the detected nw_rise (combinational), matching the engine's end-of-command rule.

## Test plan

- **Single read:** req0 read, addr 0x000010, len 0; engine model returns 0x5A.
  - Expect out_grant = 01 at N+1, one enable-drop at the first nw_rise, out_rdata = 0x5A with one out_rvalid, out_done once.
- **Burst read:** req1 read, len 3; model returns 0x01..0x04.
  - Expect four out_rvalid with values 0x01, 0x02, 0x03, 0x04 in order.
  - Expect enable continuous until the 4th nw_rise; out_flash_addr stays at the start address throughout.
- **Tie arbitration:** both in_req high from reset.
  - Expect requester 0 burst first, then requester 1, then 0 again while both stay high.
  - Expect out_grant never 11.
- **Write burst:** req0 write, len 2, in_wdata 0x23, then 0x24 and 0x25 after each out_wnext.
  - Expect out_flash_read = 0, exactly 2 out_wnext pulses, out_flash_data sequence 0x23/0x24/0x25, out_done.
- **Reset mid-burst:** assert in_rst = 0 during the 2nd word of a len-5 read.
  - Expect all outputs at reset values next edge, no out_done.
  - Expect a fresh request afterwards to be granted normally.
- **Coincident events:** model drives nw_rise and wf_fall in the same cycle at word_ctr == len − 1.
  - Expect the counter to increment and enable to stay high.
  - Expect enable to drop at the following nw_rise.
